// File: rtl/ks_data_path_param_pkg.sv
// Shared types and constants for the parametrised K&S data path.
// Decoded-instruction members for the extended ALU always exist; KS_ALU_EXT_EN gates their use.
package ks_param_pkg;

  typedef enum logic [4:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNEG, I_BNNEG, I_BNZERO, I_HALT,
    I_XOR, I_SHL, I_SHR, I_NOT
  } decoded_instruction_type;

  localparam logic [7:0] OPC_NOP    = 8'h00;
  localparam logic [7:0] OPC_LOAD   = 8'h81;
  localparam logic [7:0] OPC_STORE  = 8'h82;
  localparam logic [7:0] OPC_MOVE   = 8'h91;
  localparam logic [7:0] OPC_ADD    = 8'hA1;
  localparam logic [7:0] OPC_SUB    = 8'hA2;
  localparam logic [7:0] OPC_AND    = 8'hA3;
  localparam logic [7:0] OPC_OR     = 8'hA4;
  localparam logic [7:0] OPC_XOR    = 8'hA5;
  localparam logic [7:0] OPC_SHL    = 8'hA6;
  localparam logic [7:0] OPC_SHR    = 8'hA7;
  localparam logic [7:0] OPC_NOT    = 8'hA8;
  localparam logic [7:0] OPC_BRANCH = 8'h01;
  localparam logic [7:0] OPC_BZERO  = 8'h02;
  localparam logic [7:0] OPC_BNEG   = 8'h03;
  localparam logic [7:0] OPC_BNNEG  = 8'h0A;
  localparam logic [7:0] OPC_BNZERO = 8'h0B;
  localparam logic [7:0] OPC_HALT   = 8'hFF;

  localparam logic [2:0] ALU_OR  = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;
  localparam logic [2:0] ALU_NOT = 3'b111;

endpackage

// File: rtl/ks_data_path_param_alu.sv
// Combinational DATA_W-bit ALU with zero/neg/unsigned/signed overflow flags.
// Define KS_ALU_EXT_EN to enable XOR, SHL1, SHR1 and NOT; otherwise op codes 1xx yield 0.
module ks_alu
  import ks_param_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        operation,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              neg,
  output logic              uov,
  output logic              sov
);

  logic [DATA_W:0] sum;

  // The extra top bit of sum is the carry for ADD and the borrow for SUB.
  always_comb begin
    result = '0;
    uov    = 1'b0;
    sov    = 1'b0;
    sum    = '0;
    case (operation)
      ALU_OR:  result = a | b;
      ALU_AND: result = a & b;
      ALU_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        uov    = sum[DATA_W];
        sov    = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[DATA_W-1:0];
        uov    = sum[DATA_W];
        sov    = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
`ifdef KS_ALU_EXT_EN
      ALU_XOR: result = a ^ b;
      ALU_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        uov    = a[DATA_W-1];
      end
      ALU_SHR: result = {1'b0, a[DATA_W-1:1]};
      ALU_NOT: result = ~a;
`endif
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign neg  = result[DATA_W-1];

endmodule

// File: rtl/ks_data_path_param.sv
// Parametrised K&S data path: IR, decoder, 4-entry register file, ALU, flags, PC and address muxes.
// Optional macro KS_ALU_EXT_EN adds the XOR/SHL/SHR/NOT instructions and ALU ops.
module ks_data_path_param
  import ks_param_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int PC_RESET = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [2:0]              operation,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);

  logic [15:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] addr_field;
  logic [DATA_W-1:0] regs [4];
  logic [1:0]        src_a, src_b, dst_c;
  logic [DATA_W-1:0] bus_a, bus_b, alu_result;
  logic              alu_zero, alu_neg, alu_uov, alu_sov;
  logic              unused_ir_bits;

  assign addr_field     = ir[ADDR_W-1:0];
  assign unused_ir_bits = ^ir;

  always_comb begin
    decoded_instruction = I_NOP;
    src_a = 2'd0;
    src_b = 2'd0;
    dst_c = 2'd0;
    case (ir[15:8])
      OPC_LOAD: begin
        decoded_instruction = I_LOAD;
        dst_c = ir[ADDR_W+1:ADDR_W];
      end
      OPC_STORE: begin
        decoded_instruction = I_STORE;
        src_a = ir[ADDR_W+1:ADDR_W];
      end
      OPC_MOVE: begin
        decoded_instruction = I_MOVE;
        src_a = ir[1:0];
        src_b = ir[1:0];
        dst_c = ir[3:2];
      end
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR
`ifdef KS_ALU_EXT_EN
      , OPC_XOR, OPC_SHL, OPC_SHR, OPC_NOT
`endif
      : begin
        src_a = ir[1:0];
        src_b = ir[3:2];
        dst_c = ir[5:4];
        case (ir[15:8])
          OPC_ADD: decoded_instruction = I_ADD;
          OPC_SUB: decoded_instruction = I_SUB;
          OPC_AND: decoded_instruction = I_AND;
          OPC_OR:  decoded_instruction = I_OR;
`ifdef KS_ALU_EXT_EN
          OPC_XOR: decoded_instruction = I_XOR;
          OPC_SHL: decoded_instruction = I_SHL;
          OPC_SHR: decoded_instruction = I_SHR;
          OPC_NOT: decoded_instruction = I_NOT;
`endif
          default: decoded_instruction = I_NOP;
        endcase
      end
      OPC_BRANCH: decoded_instruction = I_BRANCH;
      OPC_BZERO:  decoded_instruction = I_BZERO;
      OPC_BNEG:   decoded_instruction = I_BNEG;
      OPC_BNNEG:  decoded_instruction = I_BNNEG;
      OPC_BNZERO: decoded_instruction = I_BNZERO;
      OPC_HALT:   decoded_instruction = I_HALT;
      default:    decoded_instruction = I_NOP;
    endcase
  end

  assign bus_a    = regs[src_a];
  assign bus_b    = regs[src_b];
  assign data_out = bus_a;
  assign ram_addr = addr_sel ? pc : addr_field;

  ks_alu #(.DATA_W(DATA_W)) u_alu (
    .operation (operation),
    .a         (bus_a),
    .b         (bus_b),
    .result    (alu_result),
    .zero      (alu_zero),
    .neg       (alu_neg),
    .uov       (alu_uov),
    .sov       (alu_sov)
  );

  // Reset dominates every enable, so an instruction caught mid-flight is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir                <= '0;
      pc                <= ADDR_W'(PC_RESET);
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (ir_enable) ir <= data_in[15:0];
      if (pc_enable) pc <= branch ? addr_field : pc + ADDR_W'(1);
      if (write_reg_enable) regs[dst_c] <= c_sel ? data_in : alu_result;
      if (flags_reg_enable) begin
        zero_op           <= alu_zero;
        neg_op            <= alu_neg;
        unsigned_overflow <= alu_uov;
        signed_overflow   <= alu_sov;
      end
    end
  end

endmodule

// File: tb/tb_ks_data_path_param.sv
// Directed self-checking bench for ks_data_path_param (default build, DATA_W=16, ADDR_W=5).
// A second instance with PC_RESET=3 shares the stimulus to check the reset vector.
module tb_ks_data_path_param;
  import ks_param_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [2:0]  operation;
  logic        write_reg_enable, flags_reg_enable;
  logic [15:0] data_in;

  decoded_instruction_type decoded_instruction, decoded_instruction_b;
  logic        zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic        zero_op_b, neg_op_b, unsigned_overflow_b, signed_overflow_b;
  logic [4:0]  ram_addr, ram_addr_b;
  logic [15:0] data_out, data_out_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ks_data_path_param #(.DATA_W(16), .ADDR_W(5), .PC_RESET(0)) dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .decoded_instruction(decoded_instruction), .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .ram_addr(ram_addr), .data_out(data_out), .data_in(data_in)
  );

  ks_data_path_param #(.DATA_W(16), .ADDR_W(5), .PC_RESET(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .decoded_instruction(decoded_instruction_b), .zero_op(zero_op_b), .neg_op(neg_op_b),
    .unsigned_overflow(unsigned_overflow_b), .signed_overflow(signed_overflow_b),
    .ram_addr(ram_addr_b), .data_out(data_out_b), .data_in(data_in)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_flags(input string tag, input logic z, input logic n, input logic u, input logic s);
    check_output({tag, " flags{z,n,u,s}"},
                 {28'd0, zero_op, neg_op, unsigned_overflow, signed_overflow},
                 {28'd0, z, n, u, s});
  endtask

  task automatic load_ir(input logic [15:0] word);
    ir_enable = 1'b1; data_in = word;
    write_reg_enable = 1'b0; flags_reg_enable = 1'b0; pc_enable = 1'b0;
    tick();
    ir_enable = 1'b0;
  endtask

  // LOAD with c field in IR[6:5], then write data_in into that register.
  task automatic write_reg(input logic [1:0] idx, input logic [15:0] value);
    load_ir({8'h81, 1'b0, idx, 5'd0});
    c_sel = 1'b1; data_in = value; write_reg_enable = 1'b1;
    tick();
    write_reg_enable = 1'b0;
  endtask

  // STORE puts R[idx] on data_out through the a field in IR[6:5].
  task automatic expect_reg(input string tag, input logic [1:0] idx, input logic [15:0] value);
    load_ir({8'h82, 1'b0, idx, 5'd0});
    check_output(tag, {16'd0, data_out}, {16'd0, value});
  endtask

  task automatic apply_stimulus(input logic [15:0] ir_word, input logic [2:0] op);
    load_ir(ir_word);
    operation = op; c_sel = 1'b0; write_reg_enable = 1'b1; flags_reg_enable = 1'b1;
    tick();
    write_reg_enable = 1'b0; flags_reg_enable = 1'b0;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; branch = 1'b0; pc_enable = 1'b1; ir_enable = 1'b1; addr_sel = 1'b1;
    c_sel = 1'b1; operation = 3'b001; write_reg_enable = 1'b1; flags_reg_enable = 1'b1;
    data_in = 16'h8147;
    tick();
    check_output("reset pc", {27'd0, ram_addr}, 32'd0);
    check_output("reset pc vector 3", {27'd0, ram_addr_b}, 32'd3);
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("reset decode", 32'(decoded_instruction), 32'(I_NOP));
    check_output("reset r0", {16'd0, data_out}, 32'd0);

    rst_n = 1'b1; pc_enable = 1'b0; ir_enable = 1'b0;
    write_reg_enable = 1'b0; flags_reg_enable = 1'b0;

    // ADD signed overflow
    write_reg(2'd0, 16'h7FFF);
    write_reg(2'd1, 16'h0001);
    apply_stimulus(16'hA124, 3'b001);
    check_output("decode add", 32'(decoded_instruction), 32'(I_ADD));
    check_flags("add 7fff+1", 1'b0, 1'b1, 1'b0, 1'b1);
    expect_reg("add 7fff+1 r2", 2'd2, 16'h8000);

    // ADD carry out to zero
    write_reg(2'd0, 16'hFFFF);
    apply_stimulus(16'hA124, 3'b001);
    check_flags("add ffff+1", 1'b1, 1'b0, 1'b1, 1'b0);
    expect_reg("add ffff+1 r2", 2'd2, 16'h0000);

    // Flags hold while the ALU produces 0x1234
    write_reg(2'd0, 16'h1234);
    write_reg(2'd1, 16'h0000);
    load_ir(16'hA124);
    operation = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("flag hold zero", {31'd0, zero_op}, 32'd1);
    end

    // SUB borrow
    write_reg(2'd0, 16'h0003);
    write_reg(2'd1, 16'h0005);
    apply_stimulus(16'hA224, 3'b010);
    check_output("decode sub", 32'(decoded_instruction), 32'(I_SUB));
    check_flags("sub 3-5", 1'b0, 1'b1, 1'b1, 1'b0);
    expect_reg("sub 3-5 r2", 2'd2, 16'hFFFE);

    // SUB signed overflow
    write_reg(2'd0, 16'h8000);
    write_reg(2'd1, 16'h0001);
    apply_stimulus(16'hA224, 3'b010);
    check_flags("sub 8000-1", 1'b0, 1'b0, 1'b0, 1'b1);
    expect_reg("sub 8000-1 r2", 2'd2, 16'h7FFF);

    // OR and AND into R3
    write_reg(2'd0, 16'h00F0);
    write_reg(2'd1, 16'h0FF0);
    apply_stimulus(16'hA434, 3'b000);
    check_flags("or", 1'b0, 1'b0, 1'b0, 1'b0);
    expect_reg("or r3", 2'd3, 16'h0FF0);
    apply_stimulus(16'hA334, 3'b011);
    expect_reg("and r3", 2'd3, 16'h00F0);

    // Extended op codes in the default build give zero
    apply_stimulus(16'hA434, 3'b100);
    check_flags("op 100 default", 1'b1, 1'b0, 1'b0, 1'b0);
    expect_reg("op 100 r3", 2'd3, 16'h0000);

    // Decode table spot checks
    load_ir(16'hA500);
    check_output("decode a5 default", 32'(decoded_instruction), 32'(I_NOP));
    load_ir(16'hFF00);
    check_output("decode halt", 32'(decoded_instruction), 32'(I_HALT));
    load_ir(16'h0B00);
    check_output("decode bnzero", 32'(decoded_instruction), 32'(I_BNZERO));
    load_ir(16'h9100);
    check_output("decode move", 32'(decoded_instruction), 32'(I_MOVE));
    load_ir(16'h5500);
    check_output("decode unknown", 32'(decoded_instruction), 32'(I_NOP));

    // PC branch, wrap and increment
    addr_sel = 1'b1;
    load_ir(16'h011F);
    check_output("decode branch", 32'(decoded_instruction), 32'(I_BRANCH));
    branch = 1'b1; pc_enable = 1'b1;
    tick();
    check_output("pc branch 31", {27'd0, ram_addr}, 32'd31);
    branch = 1'b0;
    tick();
    check_output("pc wrap", {27'd0, ram_addr}, 32'd0);
    tick();
    check_output("pc increment", {27'd0, ram_addr}, 32'd1);
    load_ir(16'h010C);
    branch = 1'b1; pc_enable = 1'b1;
    tick();
    pc_enable = 1'b0; branch = 1'b0;
    check_output("pc branch 12", {27'd0, ram_addr}, 32'd12);
    tick();
    check_output("pc hold", {27'd0, ram_addr}, 32'd12);

    // LOAD / STORE addressing and data
    load_ir(16'h8147);
    addr_sel = 1'b0;
    #1;
    check_output("load ram_addr", {27'd0, ram_addr}, 32'd7);
    c_sel = 1'b1; data_in = 16'hBEEF; write_reg_enable = 1'b1;
    tick();
    write_reg_enable = 1'b0;
    load_ir(16'h8247);
    check_output("store data_out", {16'd0, data_out}, 32'h0000BEEF);
    check_output("store ram_addr", {27'd0, ram_addr}, 32'd7);

    // MOVE reading and writing R2 on the same edge
    load_ir(16'h910A);
    c_sel = 1'b1; data_in = 16'h1111; write_reg_enable = 1'b1;
    #1;
    check_output("same-edge old value", {16'd0, data_out}, 32'h0000BEEF);
    tick();
    write_reg_enable = 1'b0;
    check_output("same-edge new value", {16'd0, data_out}, 32'h00001111);

    // Reset mid-instruction clears IR and registers
    rst_n = 1'b0; ir_enable = 1'b1; data_in = 16'hA124; write_reg_enable = 1'b1;
    tick();
    rst_n = 1'b1; ir_enable = 1'b0; write_reg_enable = 1'b0;
    check_output("mid reset decode", 32'(decoded_instruction), 32'(I_NOP));
    expect_reg("mid reset r2", 2'd2, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
